// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: two-requester round-robin packet arbiter feeding a single
// registered valid/ready output stage. A grant is held for a whole packet,
// and every completed packet bumps a saturating per-requester counter.
module rr_mux_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    input  logic             y_ready,
    output logic             s,
    output logic             prio,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic               prio_reg, prio_next;
    logic               s_reg, s_next;
    logic               y_valid_reg;
    logic [WIDTH-1:0]   y_data_reg;
    logic               y_last_reg;

    logic               out_free;
    logic               acc_a, acc_b, acc_any;
    logic [WIDTH-1:0]   acc_data;
    logic               acc_last;
    logic [1:0]         pkt_done;
    logic [2*CNT_W-1:0] cnt_all;

    // The output register can take a beat when empty or draining this cycle.
    // Ready is masked during reset so no beat is offered to a state being cleared.
    assign out_free = !y_valid_reg || y_ready;
    assign a_ready  = rst_n && (state_reg == GNT_A) && out_free;
    assign b_ready  = rst_n && (state_reg == GNT_B) && out_free;

    assign acc_a    = a_valid && a_ready;
    assign acc_b    = b_valid && b_ready;
    assign acc_any  = acc_a || acc_b;
    assign acc_data = acc_b ? b_data : a_data;
    assign acc_last = acc_b ? b_last : a_last;
    assign pkt_done = {acc_b && b_last, acc_a && a_last};

    // Arbitration in IDLE, grant release on the accepted last beat.
    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        s_next     = s_reg;
        case (state_reg)
            IDLE: begin
                if (a_valid && (!b_valid || !prio_reg)) begin
                    state_next = GNT_A;
                    s_next     = 1'b0;
                end else if (b_valid) begin
                    state_next = GNT_B;
                    s_next     = 1'b1;
                end
            end
            GNT_A: begin
                if (pkt_done[0]) begin
                    state_next = IDLE;
                    prio_next  = 1'b1;
                    s_next     = 1'b0;
                end
            end
            GNT_B: begin
                if (pkt_done[1]) begin
                    state_next = IDLE;
                    prio_next  = 1'b0;
                    s_next     = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                s_next     = 1'b0;
            end
        endcase
    end

    // Grant state, round-robin pointer and mux select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            s_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            s_reg     <= s_next;
        end
    end

    // Output stage: load on accept, empty on drain, hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_valid_reg <= 1'b0;
            y_data_reg  <= '0;
            y_last_reg  <= 1'b0;
        end else if (acc_any) begin
            y_valid_reg <= 1'b1;
            y_data_reg  <= acc_data;
            y_last_reg  <= acc_last;
        end else if (y_valid_reg && y_ready) begin
            y_valid_reg <= 1'b0;
        end
    end

    // One saturating completed-packet counter per requester (0 = A, 1 = B).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Count a finished packet unless the counter is already all-ones.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (pkt_done[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign cnt_all[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    assign a_cnt   = cnt_all[0 +: CNT_W];
    assign b_cnt   = cnt_all[CNT_W +: CNT_W];
    assign y_valid = y_valid_reg;
    assign y_data  = y_data_reg;
    assign y_last  = y_last_reg;
    assign s       = s_reg;
    assign prio    = prio_reg;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: packet sources built from queues, a packet-level
// arbitration model (owner / pointer / output slot) and an output scoreboard.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             a_valid, a_last, a_ready;
    logic             b_valid, b_last, b_ready;
    logic [WIDTH-1:0] a_data, b_data, y_data;
    logic             y_valid, y_last, y_ready, s, prio;
    logic [CNT_W-1:0] a_cnt, b_cnt;

    rr_mux_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
        .s(s), .prio(prio), .a_cnt(a_cnt), .b_cnt(b_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Pending source beats, expected output beats, delivered output log ({last,data}).
    logic [8:0] qa[$], qb[$], sb[$], dlog[$];
    int pa = 100, pb = 100, py = 100;

    // Reference model: who owns the datapath (0 none, 1 A, 2 B), pointer, output slot.
    int         owner = 0;
    bit         m_prio = 0, m_yv = 0, m_yl = 0, m_known = 0;
    logic [7:0] m_yd = 8'h00;
    int         m_acnt = 0, m_bcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        a_valid = (qa.size() > 0) && ($urandom_range(99) < pa);
        b_valid = (qb.size() > 0) && ($urandom_range(99) < pb);
        a_data  = a_valid ? qa[0][7:0] : 8'($urandom);
        a_last  = a_valid ? qa[0][8] : 1'($urandom);
        b_data  = b_valid ? qb[0][7:0] : 8'($urandom);
        b_last  = b_valid ? qb[0][8] : 1'($urandom);
        y_ready = ($urandom_range(99) < py);
    endtask

    // One clock: drive, check readiness and delivered beat at negedge, step model, check registers.
    task automatic tick();
        bit         rdy, ea, eb, acc_a, acc_b, av, bv;
        logic [8:0] beat, exp_beat;
        drive();
        @(negedge clk);
        av  = a_valid;
        bv  = b_valid;
        rdy = !m_yv || y_ready;
        ea  = rst_n && (owner == 1) && rdy;
        eb  = rst_n && (owner == 2) && rdy;
        if (m_known) begin
            chk("a_ready", a_ready, ea);
            chk("b_ready", b_ready, eb);
        end
        if (m_known && rst_n && m_yv && y_ready) begin
            exp_beat = (sb.size() > 0) ? sb.pop_front() : 9'bx;
            chk("y_beat", {y_last, y_data}, exp_beat);
            dlog.push_back({y_last, y_data});
        end
        acc_a = ea && av;
        acc_b = eb && bv;
        beat  = acc_a ? {a_last, a_data} : {b_last, b_data};
        @(posedge clk);
        #1;
        if (!rst_n) begin
            owner = 0; m_prio = 0; m_yv = 0; m_yd = 8'h00; m_yl = 0;
            m_acnt = 0; m_bcnt = 0; m_known = 1;
            sb.delete();
        end else begin
            if (acc_a || acc_b) begin
                sb.push_back(beat);
                m_yv = 1; m_yd = beat[7:0]; m_yl = beat[8];
                if (acc_a) void'(qa.pop_front());
                else       void'(qb.pop_front());
            end else if (m_yv && y_ready) begin
                m_yv = 0;
            end
            if (owner == 0) begin
                if (av && (!bv || !m_prio)) owner = 1;
                else if (bv)                owner = 2;
            end else if ((acc_a || acc_b) && beat[8]) begin
                if (owner == 1) begin
                    m_prio = 1;
                    if (m_acnt < SAT) m_acnt++;
                end else begin
                    m_prio = 0;
                    if (m_bcnt < SAT) m_bcnt++;
                end
                owner = 0;
            end
        end
        if (m_known) begin
            chk("y_valid", y_valid, m_yv);
            chk("y_data", y_data, m_yd);
            chk("y_last", y_last, m_yl);
            chk("s", s, (owner == 2));
            chk("prio", prio, m_prio);
            chk("a_cnt", a_cnt, m_acnt);
            chk("b_cnt", b_cnt, m_bcnt);
        end
    endtask

    task automatic push_pkt(input int who, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            if (who == 0) qa.push_back({(i == len - 1), 8'(base + i)});
            else          qb.push_back({(i == len - 1), 8'(base + i)});
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((qa.size() > 0 || qb.size() > 0 || m_yv) && k < 300) begin
            tick();
            k++;
        end
        chk("drain_timeout", qa.size() + qb.size() + int'(m_yv), 0);
        tick();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        qa.delete();
        qb.delete();
        rst_n = 1'b1;
    endtask

    logic [8:0] exp_order [8];

    initial begin
        rst_n = 1'b0;
        drive();

        // Reset and idle with no requests.
        do_reset(2);
        for (int i = 0; i < 3; i++) tick();
        chk("idle_y_valid", y_valid, 0);
        chk("idle_a_ready", a_ready, 0);

        // Contention: both requesters with back-to-back 2-beat packets.
        dlog.delete();
        push_pkt(0, 2, 8'hA0); push_pkt(0, 2, 8'hA0);
        push_pkt(1, 2, 8'hB0); push_pkt(1, 2, 8'hB0);
        wait_drain();
        exp_order = '{9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1};
        chk("order_len", dlog.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("order", (i < dlog.size()) ? dlog[i] : 9'bx, exp_order[i]);

        // Single 3-beat packet from A after a fresh reset.
        do_reset(2);
        dlog.delete();
        qa.push_back(9'h011); qa.push_back(9'h022); qa.push_back(9'h133);
        wait_drain();
        chk("single_a_cnt", a_cnt, 1);
        chk("single_prio", prio, 1);
        chk("single_beats", dlog.size(), 3);

        // Backpressure for 3 cycles mid-packet.
        dlog.delete();
        push_pkt(0, 4, 8'h40);
        tick(); tick();
        py = 0;
        for (int i = 0; i < 3; i++) tick();
        py = 100;
        wait_drain();
        chk("bp_beats", dlog.size(), 4);

        // Locked grant: A stalls while B requests.
        push_pkt(0, 3, 8'h60);
        push_pkt(1, 1, 8'h70);
        pb = 0;
        tick(); tick();
        pa = 0; pb = 100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lock_b_ready", b_ready, 0);
        end
        pa = 100;
        wait_drain();

        // Reset in the middle of a B packet.
        pa = 100; pb = 100;
        push_pkt(1, 4, 8'h80);
        tick(); tick(); tick();
        do_reset(1);
        chk("mid_rst_y_valid", y_valid, 0);
        chk("mid_rst_b_cnt", b_cnt, 0);
        tick();

        // Counter saturation with five A packets.
        for (int i = 0; i < 5; i++) push_pkt(0, 1, 8'(8'hC0 + i));
        wait_drain();
        chk("sat_a_cnt", a_cnt, SAT);

        // Randomized traffic with stalls, backpressure and rare resets.
        pa = 60; pb = 60; py = 70;
        for (int c = 0; c < 1500; c++) begin
            if (qa.size() < 3) push_pkt(0, $urandom_range(1, 4), 8'($urandom));
            if (qb.size() < 3) push_pkt(1, $urandom_range(1, 4), 8'($urandom));
            if ($urandom_range(399) == 0) do_reset(1);
            else tick();
        end
        py = 100; pa = 100; pb = 100;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
